invg_ctrl: RTL and testbench
============================

# invg_ctrl

Access controller for the 13-bit × 2048-entry distributed coefficient RAM that holds the inverse polynomial in the SNTRUP757 datapath. It sits between that RAM and its clients and owns all three of the RAM's accesses. It provides a write port for the key-decode loader, a zero-fill sequencer for the first P coefficients, and a burst read streamer with valid/ready that feeds the multiplier. A single FSM sequences the block, and it drives the RAM's write-enable, write-address, write-data and read-address directly.

## Interface
- RAM_WIDTH, 13, coefficient width.
- RAM_ADDR_BITS, 11, RAM address width.
- P, 757, polynomial length; the clear range is 0..P-1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr_start  in  1  pulse; request zero-fill of entries 0..P-1.
- rd_start  in  1  pulse; request a stream read.
- rd_base  in  RAM_ADDR_BITS  first read address, sampled with rd_start.
- rd_len  in  RAM_ADDR_BITS  beat count, sampled with rd_start.
- wr_valid, wr_ready  in/out  1  write handshake.
- wr_addr, wr_data  in  RAM_ADDR_BITS / RAM_WIDTH  write request.
- out_valid, out_ready  out/in  1  stream handshake.
- out_data  out  RAM_WIDTH  stream coefficient.
- out_last  out  1  asserted with the final beat.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a clear or stream completes.
- ram_we, ram_waddr, ram_wdata  out  1 / RAM_ADDR_BITS / RAM_WIDTH  RAM write port.
- ram_raddr  out  RAM_ADDR_BITS  RAM read address.
- ram_rdata  in  RAM_WIDTH  RAM asynchronous read data.

## Operation
- **States:** IDLE, CLEAR, STREAM.
- **Reset values:** state IDLE; out_valid, out_last, done, busy, ram_we all 0; out_data, ram_waddr, ram_wdata, ram_raddr all 0.
- **IDLE starts:**
  - clr_start → CLEAR, with the clear counter at 0.
  - Otherwise rd_start → STREAM, with ptr=rd_base and rem=rd_len.
  - clr_start and rd_start together: CLEAR wins and rd_start is dropped.
  - Starts received in any other state are ignored.
- **CLEAR:**
  - Each cycle: ram_we=1, ram_waddr=cnt, ram_wdata=0, then cnt++.
  - After the write with cnt=P-1: pulse done and return to IDLE.
  - wr_ready=0 throughout CLEAR.
- **Write port:**
  - wr_ready=1 in IDLE and STREAM, provided no clr_start is being accepted that cycle.
  - On wr_valid&&wr_ready the block drives ram_we=1, ram_waddr=wr_addr, ram_wdata=wr_data combinationally.
- **STREAM:**
  - ram_raddr=ptr.
  - Load condition: (!out_valid || out_ready) && rem≠0.
  - On a load: out_data←ram_rdata, out_valid←1, out_last←(rem==1), ptr←ptr+1, rem←rem−1.
  - When out_valid && out_ready and no load occurs: out_valid←0 and out_last←0.
  - When the last beat is consumed (out_valid&&out_ready&&out_last): pulse done and return to IDLE.
- **Boundary cases:**
  - rd_len=0: no beats. Enter STREAM, pulse done on the next cycle, return to IDLE.
  - Address wrap: ptr increments modulo 2^RAM_ADDR_BITS, so 2047 is followed by 0.
  - A write to address ptr in the same cycle as a load: the load captures the old value (asynchronous read before the edge). The new value is visible on later reads.
  - rst_n low mid-operation: immediately IDLE with the reset values; any partial clear or stream is abandoned and no done pulse is issued.

## Timing
- **Write:** RAM updated at the edge on which the wr handshake completes; 0 cycles of added latency.
- **Clear:** clr_start sampled at edge t. Writes occur in cycles t+1..t+P. done is high in cycle t+P+1. busy is high from t+1 through t+P+1.
- **Stream:**
  - rd_start sampled at edge t; STREAM from t+1; first out_valid in cycle t+2.
  - With out_ready held at 1: one beat per cycle, and done appears the cycle after the last beat.
  - Backpressure: out_data, out_last and ptr hold stable while out_valid && !out_ready.
- done is always exactly one cycle wide, and busy is 0 in the cycle after done.

## Structure
- Shared package, invg_pkg: RAM_WIDTH, RAM_ADDR_BITS, P, and the state enum (IDLE, CLEAR, STREAM).
- Single module; no sub-module.
- The RAM stays external and is instantiated beside this controller by its parent.

## Test plan
- Reset, then clr_start → ram_we high for 757 consecutive cycles at addresses 0..756 with data 0, then done; entry 757 unchanged.
- Write 0x1ABC to address 5, then rd_start base=5 len=1 → a single beat 0x1ABC with out_last=1, then done.
- Preload addresses 2045..2047 and 0..1 with 1..5, then rd_start base=2045 len=5 under random out_ready → beats 1,2,3,4,5 in order, stable under stall, last only on 5.
- clr_start and rd_start in the same cycle → CLEAR runs and no stream beats are produced; a rd_start mid-clear is ignored.
- During a stream, write 0x0777 to the address being loaded → that beat carries the old value and a re-read returns 0x0777; rd_len=0 → done one cycle after entering STREAM with no out_valid.
- Assert rst_n low mid-stream → out_valid=0 and busy=0 immediately, with no done pulse.

Source files
------------

// File: rtl/invg_pkg.sv
// Shared constants and state encoding for the inverse-polynomial coefficient RAM controller.
package invg_pkg;

  localparam int unsigned RAM_WIDTH     = 13;
  localparam int unsigned RAM_ADDR_BITS = 11;
  localparam int unsigned P             = 757;

  localparam logic [RAM_ADDR_BITS-1:0] CLR_LAST = RAM_ADDR_BITS'(P - 1);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StStream
  } state_e;

endpackage

// File: rtl/invg_ctrl.sv
// Owns the inverse-polynomial coefficient RAM: loader write port, zero-fill of 0..P-1,
// and a valid/ready burst read streamer feeding the multiplier.
module invg_ctrl
  import invg_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_start,
  input  logic                     rd_start,
  input  logic [RAM_ADDR_BITS-1:0] rd_base,
  input  logic [RAM_ADDR_BITS-1:0] rd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [RAM_ADDR_BITS-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]     wr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RAM_WIDTH-1:0]     out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_waddr,
  output logic [RAM_WIDTH-1:0]     ram_wdata,
  output logic [RAM_ADDR_BITS-1:0] ram_raddr,
  input  logic [RAM_WIDTH-1:0]     ram_rdata
);

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [RAM_ADDR_BITS-1:0] rem_q, rem_d;
  logic [RAM_WIDTH-1:0]     out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     done_q, done_d;
  logic                     load;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    load        = 1'b0;
    wr_ready    = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = '0;
    ram_wdata   = '0;
    ram_raddr   = '0;

    unique case (state_q)
      StIdle: begin
        wr_ready = !clr_start;
        if (clr_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (rd_start) begin
          state_d = StStream;
          ptr_d   = rd_base;
          rem_d   = rd_len;
        end
      end

      StClear: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CLR_LAST) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      StStream: begin
        wr_ready  = 1'b1;
        ram_raddr = ptr_q;
        load      = (!out_valid_q || out_ready) && (rem_q != '0);
        if (load) begin
          // Asynchronous read: a same-cycle write to ptr lands after this capture.
          out_data_d  = ram_rdata;
          out_valid_d = 1'b1;
          out_last_d  = (rem_q == RAM_ADDR_BITS'(1));
          ptr_d       = ptr_q + 1'b1;
          rem_d       = rem_q - 1'b1;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if ((out_valid_q && out_ready && out_last_q) || (rem_q == '0 && !out_valid_q)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    if (wr_valid && wr_ready) begin
      ram_we    = 1'b1;
      ram_waddr = wr_addr;
      ram_wdata = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  // The done cycle still counts as busy so clients see busy cover the whole operation.
  assign busy      = (state_q != StIdle) || done_q;

endmodule

// File: tb/tb_invg_ctrl.sv
// Directed self-checking bench for invg_ctrl with a behavioural async-read RAM beside it.
module tb_invg_ctrl;
  import invg_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     clr_start, rd_start;
  logic [RAM_ADDR_BITS-1:0] rd_base, rd_len;
  logic                     wr_valid, wr_ready;
  logic [RAM_ADDR_BITS-1:0] wr_addr;
  logic [RAM_WIDTH-1:0]     wr_data;
  logic                     out_valid, out_ready, out_last, busy, done;
  logic [RAM_WIDTH-1:0]     out_data;
  logic                     ram_we;
  logic [RAM_ADDR_BITS-1:0] ram_waddr, ram_raddr;
  logic [RAM_WIDTH-1:0]     ram_wdata, ram_rdata;

  logic [RAM_WIDTH-1:0] mem [2048];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  invg_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (clr_start),
    .rd_start  (rd_start),
    .rd_base   (rd_base),
    .rd_len    (rd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [RAM_ADDR_BITS-1:0] a, input logic [RAM_WIDTH-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Leaves the caller in the first STREAM cycle (t+1).
  task automatic start_rd(input logic [RAM_ADDR_BITS-1:0] b, input logic [RAM_ADDR_BITS-1:0] l);
    rd_start = 1'b1;
    rd_base  = b;
    rd_len   = l;
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  initial begin
    logic [RAM_WIDTH-1:0] exp3 [5];
    int  good, beats, dones, cyc;
    logic seen_done, prev_stall, prev_last;
    logic [RAM_WIDTH-1:0] prev_data;

    for (int i = 0; i < 2048; i++) mem[i] = 13'h1555;
    rst_n = 1'b0; clr_start = 1'b0; rd_start = 1'b0; rd_base = '0; rd_len = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_data", out_data, 0);
    chk("rst_wready", wr_ready, 1);

    // Zero-fill
    clr_start = 1'b1;
    #1 chk("clr_wready_accept", wr_ready, 0);
    @(negedge clk);
    clr_start = 1'b0;
    good = 0;
    for (int i = 0; i < int'(P); i++) begin
      if (ram_we && ram_waddr == RAM_ADDR_BITS'(i) && ram_wdata == '0 && !wr_ready && busy && !done)
        good++;
      @(negedge clk);
    end
    chk("clr_writes", good, P);
    chk("clr_done", done, 1);
    chk("clr_busy_done", busy, 1);
    chk("clr_we_end", ram_we, 0);
    @(negedge clk);
    chk("clr_done_off", done, 0);
    chk("clr_busy_off", busy, 0);
    chk("clr_mem0", mem[0], 0);
    chk("clr_mem756", mem[756], 0);
    chk("clr_mem757", mem[757], 13'h1555);

    // Single write then single-beat stream
    wr_valid = 1'b1; wr_addr = 11'd5; wr_data = 13'h1ABC;
    #1;
    chk("wr_ready", wr_ready, 1);
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_waddr, 5);
    chk("wr_data", ram_wdata, 13'h1ABC);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("wr_mem", mem[5], 13'h1ABC);
    out_ready = 1'b1;
    start_rd(11'd5, 11'd1);
    chk("s1_busy", busy, 1);
    chk("s1_nvalid", out_valid, 0);
    chk("s1_raddr", ram_raddr, 5);
    @(negedge clk);
    chk("s1_valid", out_valid, 1);
    chk("s1_data", out_data, 13'h1ABC);
    chk("s1_last", out_last, 1);
    @(negedge clk);
    chk("s1_done", done, 1);
    chk("s1_valid_off", out_valid, 0);
    @(negedge clk);
    chk("s1_done_off", done, 0);
    chk("s1_busy_off", busy, 0);

    // Wrapping stream under random backpressure
    wr(11'd2045, 13'd1); wr(11'd2046, 13'd2); wr(11'd2047, 13'd3);
    wr(11'd0, 13'd4); wr(11'd1, 13'd5);
    exp3[0] = 13'd1; exp3[1] = 13'd2; exp3[2] = 13'd3; exp3[3] = 13'd4; exp3[4] = 13'd5;
    out_ready = 1'b0;
    start_rd(11'd2045, 11'd5);
    beats = 0; seen_done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (cyc = 0; cyc < 80; cyc++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (prev_stall && out_valid) begin
        chk("s3_hold_data", out_data, prev_data);
        chk("s3_hold_last", out_last, prev_last);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (beats < 5) begin
          chk("s3_data", out_data, exp3[beats]);
          chk("s3_last", out_last, (beats == 4));
        end
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      @(negedge clk);
    end
    chk("s3_beats", beats, 5);
    chk("s3_seen_done", seen_done, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("s3_busy_off", busy, 0);

    // Simultaneous starts: clear wins, mid-clear rd_start ignored
    clr_start = 1'b1; rd_start = 1'b1; rd_base = '0; rd_len = 11'd3;
    @(negedge clk);
    clr_start = 1'b0; rd_start = 1'b0;
    beats = 0; dones = 0;
    for (int i = 0; i < int'(P) + 6; i++) begin
      rd_start = (i == 10);
      if (out_valid) beats++;
      if (done) dones++;
      @(negedge clk);
    end
    rd_start = 1'b0;
    chk("s4_beats", beats, 0);
    chk("s4_dones", dones, 1);
    chk("s4_busy", busy, 0);

    // Write racing a load, then re-read; then zero-length stream
    wr(11'd10, 13'h0AA);
    wr(11'd11, 13'h0BB);
    start_rd(11'd10, 11'd2);
    wr_valid = 1'b1; wr_addr = 11'd10; wr_data = 13'h0777;
    #1 chk("s5_wr_ready", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("s5_old_data", out_data, 13'h0AA);
    chk("s5_last0", out_last, 0);
    @(negedge clk);
    chk("s5_data1", out_data, 13'h0BB);
    chk("s5_last1", out_last, 1);
    @(negedge clk);
    chk("s5_done", done, 1);
    @(negedge clk);
    start_rd(11'd10, 11'd1);
    @(negedge clk);
    chk("s5_reread", out_data, 13'h0777);
    @(negedge clk);
    @(negedge clk);
    start_rd(11'd100, 11'd0);
    chk("z_busy", busy, 1);
    chk("z_nvalid", out_valid, 0);
    chk("z_ndone", done, 0);
    @(negedge clk);
    chk("z_done", done, 1);
    chk("z_nvalid2", out_valid, 0);
    @(negedge clk);
    chk("z_busy_off", busy, 0);

    // Reset mid-stream
    out_ready = 1'b0;
    start_rd(11'd0, 11'd20);
    @(negedge clk);
    chk("r_valid_pre", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("r_valid", out_valid, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_last", out_last, 0);
    chk("r_raddr", ram_raddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy || out_valid) dones++;
    end
    chk("r_quiet", dones, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
